// File: rtl/inst_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue.
interface inst_queue_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             flush;
  logic             fs_valid;
  logic [31:0]      fs_pc;
  logic [31:0]      fs_inst;
  logic             fs_ex_adel;
  logic             fs_allowin;
  logic             ds_allowin;
  logic             ds_valid;
  logic [31:0]      ds_pc;
  logic [31:0]      ds_inst;
  logic             ds_ex_adel;
  logic [CNT_W-1:0] count;

  // Pipeline side: drives fetch pushes, decode acceptance and flush
  modport master (
    output flush, fs_valid, fs_pc, fs_inst, fs_ex_adel, ds_allowin,
    input  fs_allowin, ds_valid, ds_pc, ds_inst, ds_ex_adel, count
  );

  // Queue side
  modport slave (
    input  flush, fs_valid, fs_pc, fs_inst, fs_ex_adel, ds_allowin,
    output fs_allowin, ds_valid, ds_pc, ds_inst, ds_ex_adel, count
  );
endinterface

// File: rtl/inst_queue.sv
// Show-ahead instruction FIFO between fetch and decode, emptied on flush.
module inst_queue #(
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         resetn,
  inst_queue_if.slave  q
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ex_adel;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic   fs_allowin_c;
  logic   ds_valid_c;
  logic   push_c;
  logic   pop_c;
  entry_t wr_entry_c;
  entry_t head_c;

  // Handshake status comes only from registered occupancy
  assign fs_allowin_c = (count_q != CNT_W'(DEPTH));
  assign ds_valid_c   = (count_q != '0);

  // Flush suppresses both sides of the transfer in the same cycle
  assign push_c = q.fs_valid & fs_allowin_c & ~q.flush;
  assign pop_c  = ds_valid_c & q.ds_allowin & ~q.flush;

  assign wr_entry_c = '{pc: q.fs_pc, inst: q.fs_inst, ex_adel: q.fs_ex_adel};
  assign head_c     = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; flush returns everything to zero
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
      else if (pop_c && !push_c) count_d = count_q - CNT_W'(1);
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= wr_entry_c;
  end

  // Head is shown ahead and zeroed while the queue is empty
  assign q.fs_allowin = fs_allowin_c;
  assign q.ds_valid   = ds_valid_c;
  assign q.ds_pc      = ds_valid_c ? head_c.pc      : 32'h0;
  assign q.ds_inst    = ds_valid_c ? head_c.inst    : 32'h0;
  assign q.ds_ex_adel = ds_valid_c ? head_c.ex_adel : 1'b0;
  assign q.count      = count_q;

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue.
module tb_inst_queue;

  localparam int unsigned DEPTH = 8;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_errors;

  inst_queue_if #(.DEPTH(DEPTH)) bus ();

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .q      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] inst, input logic adel);
    bus.fs_valid   = 1'b1;
    bus.fs_pc      = pc;
    bus.fs_inst    = inst;
    bus.fs_ex_adel = adel;
    step();
    bus.fs_valid   = 1'b0;
  endtask

  // Occupancy bound, sampled away from the active edge
  always @(negedge clk) begin
    check("cnt_le_depth", 32'(bus.count <= 4'(DEPTH)), 32'd1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    resetn = 1'b0;
    bus.flush = 1'b0;
    bus.fs_valid = 1'b0;
    bus.fs_pc = '0;
    bus.fs_inst = '0;
    bus.fs_ex_adel = 1'b0;
    bus.ds_allowin = 1'b0;
    step();
    step();
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_ds_valid", 32'(bus.ds_valid), 32'd0);
    check("rst_fs_allowin", 32'(bus.fs_allowin), 32'd1);
    check("rst_ds_pc", bus.ds_pc, 32'h0);
    check("rst_ds_inst", bus.ds_inst, 32'h0);
    check("rst_ds_adel", 32'(bus.ds_ex_adel), 32'd0);
    resetn = 1'b1;
    step();

    // Three pushes with decode stalled, then drain in order
    push_one(32'hBFC00000, 32'h24010001, 1'b0);
    check("t1_first_lat_valid", 32'(bus.ds_valid), 32'd1);
    check("t1_first_lat_pc", bus.ds_pc, 32'hBFC00000);
    push_one(32'hBFC00004, 32'h24010002, 1'b0);
    push_one(32'hBFC00008, 32'h24010003, 1'b0);
    check("t1_count3", 32'(bus.count), 32'd3);
    check("t1_valid", 32'(bus.ds_valid), 32'd1);
    check("t1_head_pc", bus.ds_pc, 32'hBFC00000);
    check("t1_head_inst", bus.ds_inst, 32'h24010001);
    bus.ds_allowin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t1_pop_pc", bus.ds_pc, 32'hBFC00000 + 32'(4 * i));
      check("t1_pop_inst", bus.ds_inst, 32'h24010001 + 32'(i));
      step();
    end
    bus.ds_allowin = 1'b0;
    check("t1_count0", 32'(bus.count), 32'd0);
    check("t1_empty", 32'(bus.ds_valid), 32'd0);
    check("t1_empty_pc", bus.ds_pc, 32'h0);

    // Fill to DEPTH, refuse the ninth, one pop admits it a cycle later
    for (int i = 0; i < 8; i++) push_one(32'h00001000 + 32'(4 * i), 32'(i), 1'b0);
    check("t2_count8", 32'(bus.count), 32'd8);
    check("t2_full_allowin", 32'(bus.fs_allowin), 32'd0);
    bus.fs_valid = 1'b1;
    bus.fs_pc = 32'h00002000;
    bus.fs_inst = 32'h000000AA;
    step();
    step();
    check("t2_refused_count", 32'(bus.count), 32'd8);
    check("t2_refused_head", bus.ds_pc, 32'h00001000);
    bus.ds_allowin = 1'b1;
    step();
    bus.ds_allowin = 1'b0;
    check("t2_after_pop_count", 32'(bus.count), 32'd7);
    check("t2_after_pop_allowin", 32'(bus.fs_allowin), 32'd1);
    check("t2_after_pop_head", bus.ds_pc, 32'h00001004);
    step();
    bus.fs_valid = 1'b0;
    check("t2_ninth_stored", 32'(bus.count), 32'd8);
    bus.ds_allowin = 1'b1;
    for (int i = 1; i < 8; i++) begin
      check("t2_drain_pc", bus.ds_pc, 32'h00001000 + 32'(4 * i));
      step();
    end
    check("t2_ninth_pc", bus.ds_pc, 32'h00002000);
    check("t2_ninth_inst", bus.ds_inst, 32'h000000AA);
    step();
    bus.ds_allowin = 1'b0;
    check("t2_drained", 32'(bus.count), 32'd0);

    // Steady push+pop at count 4 across pointer wrap
    for (int i = 0; i < 4; i++) push_one(32'h00003000 + 32'(4 * i), 32'(i), 1'b0);
    check("t3_count4", 32'(bus.count), 32'd4);
    bus.fs_valid = 1'b1;
    bus.ds_allowin = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.fs_pc = 32'h00003000 + 32'(4 * (i + 4));
      bus.fs_inst = 32'(i + 4);
      check("t3_pop_seq_pc", bus.ds_pc, 32'h00003000 + 32'(4 * i));
      step();
      check("t3_count_hold", 32'(bus.count), 32'd4);
    end
    bus.ds_allowin = 1'b0;
    bus.fs_pc = 32'h00003000 + 32'(4 * 24);
    step();
    bus.fs_valid = 1'b0;
    check("t4_count5", 32'(bus.count), 32'd5);
    check("t4_head", bus.ds_pc, 32'h00003050);

    // Flush with concurrent push and pop request
    bus.flush = 1'b1;
    bus.fs_valid = 1'b1;
    bus.fs_pc = 32'h00005555;
    bus.ds_allowin = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.fs_valid = 1'b0;
    bus.ds_allowin = 1'b0;
    check("t4_flush_count", 32'(bus.count), 32'd0);
    check("t4_flush_valid", 32'(bus.ds_valid), 32'd0);
    check("t4_flush_pc", bus.ds_pc, 32'h0);
    push_one(32'h00004444, 32'h1, 1'b0);
    check("t4_post_flush_count", 32'(bus.count), 32'd1);
    check("t4_post_flush_head", bus.ds_pc, 32'h00004444);
    bus.ds_allowin = 1'b1;
    step();
    bus.ds_allowin = 1'b0;

    // Address-error flag travels with its entry
    push_one(32'h00000003, 32'h0, 1'b1);
    push_one(32'h00000010, 32'h0, 1'b0);
    check("t5_adel_set", 32'(bus.ds_ex_adel), 32'd1);
    check("t5_adel_pc", bus.ds_pc, 32'h00000003);
    bus.ds_allowin = 1'b1;
    step();
    check("t5_adel_clear", 32'(bus.ds_ex_adel), 32'd0);
    check("t5_next_pc", bus.ds_pc, 32'h00000010);
    step();
    bus.ds_allowin = 1'b0;
    check("t5_empty", 32'(bus.count), 32'd0);

    // Asynchronous reset between edges
    for (int i = 0; i < 6; i++) push_one(32'h00006000 + 32'(4 * i), 32'(i), 1'b0);
    check("t6_count6", 32'(bus.count), 32'd6);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_async_count", 32'(bus.count), 32'd0);
    check("t6_async_valid", 32'(bus.ds_valid), 32'd0);
    check("t6_async_allowin", 32'(bus.fs_allowin), 32'd1);
    step();
    resetn = 1'b1;
    step();
    check("t6_after_count", 32'(bus.count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
